bta_pipe_adder: RTL and testbench



---
 rtl/bta_pkg.sv | 35 +++
 rtl/rca_level.sv | 46 ++++
 rtl/bta_pipe_adder.sv | 96 +++++++++
 tb/tb_bta_pipe_adder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bta_pkg.sv
// rtl/bta_pkg.sv - shared constants and width helpers for the pipelined tree adder
//
// Contents:
//   DEF_N_OPS, DEF_W, DEF_TAG_W : default parameter values for bta_pipe_adder
//   clog2(v)                    : ceiling log2 usable in constant expressions
//   LEVELS(n_ops)               : number of adder levels in the tree
//   LVL_W(w, l)                 : width of a partial sum after level l
package bta_pkg;

    localparam int DEF_N_OPS = 8;
    localparam int DEF_W     = 16;
    localparam int DEF_TAG_W = 4;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int LEVELS(input int n_ops);
        return clog2(n_ops);
    endfunction

    // Each level adds one bit, so no partial sum can ever overflow.
    function automatic int LVL_W(input int w, input int l);
        return w + l;
    endfunction

endpackage

// File: rtl/rca_level.sv
// rtl/rca_level.sv - one combinational level of pairwise ripple-carry adders
//
// Ports:
//   ops_i : 2*NA operands of WI bits, operand j at [j*WI +: WI]
//   sgn_i : 1 = operands are two's complement (sign-extend), 0 = unsigned
//   sum_o : NA sums of WI+1 bits, sum k = operand 2k + operand 2k+1
module rca_level #(
    parameter int NA = 1,
    parameter int WI = 2
) (
    input  logic [2*NA*WI-1:0]   ops_i,
    input  logic                 sgn_i,
    output logic [NA*(WI+1)-1:0] sum_o
);

    logic [WI-1:0] a;
    logic [WI-1:0] b;
    logic [WI:0]   ax;
    logic [WI:0]   bx;
    logic [WI:0]   s;
    logic          c;

    always_comb begin
        sum_o = '0;
        a     = '0;
        b     = '0;
        ax    = '0;
        bx    = '0;
        s     = '0;
        c     = 1'b0;
        for (int k = 0; k < NA; k++) begin
            a  = ops_i[2*k*WI +: WI];
            b  = ops_i[(2*k+1)*WI +: WI];
            // One extension bit makes the WI+1-bit result exact in both modes.
            ax = {sgn_i & a[WI-1], a};
            bx = {sgn_i & b[WI-1], b};
            c  = 1'b0;
            for (int i = 0; i <= WI; i++) begin
                s[i] = ax[i] ^ bx[i] ^ c;
                c    = (ax[i] & bx[i]) | (c & (ax[i] ^ bx[i]));
            end
            sum_o[k*(WI+1) +: WI+1] = s;
        end
    end

endmodule

// File: rtl/bta_pipe_adder.sv
// rtl/bta_pipe_adder.sv - pipelined multi-operand binary-tree adder with valid/ready
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake; in_ready = out_ready | ~out_valid
//   in_ops               : N_OPS operands of W bits, operand i at [i*W +: W]
//   in_signed            : per-vector two's-complement flag
//   in_tag               : sideband tag travelling with the vector
//   out_valid / out_ready: output handshake
//   out_sum              : exact sum, W+LEVELS bits
//   out_tag              : tag of the vector that produced out_sum
module bta_pipe_adder
    import bta_pkg::*;
#(
    parameter int N_OPS = DEF_N_OPS,
    parameter int W     = DEF_W,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_OPS*W-1:0]                    in_ops,
    input  logic                                  in_signed,
    input  logic [TAG_W-1:0]                      in_tag,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LVL_W(W, LEVELS(N_OPS))-1:0]    out_sum,
    output logic [TAG_W-1:0]                      out_tag
);

    localparam int N_LVL = LEVELS(N_OPS);
    localparam int OUT_W = LVL_W(W, N_LVL);

    // Whole pipeline moves in lockstep; bubbles are kept, not collapsed.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar l = 1; l <= N_LVL; l++) begin : g_lvl
        localparam int WI = W + l - 1;
        localparam int NA = N_OPS >> l;

        logic [2*NA*WI-1:0]   src_ops;
        logic                 src_sgn;
        logic                 src_vld;
        logic [TAG_W-1:0]     src_tag;
        logic [NA*(WI+1)-1:0] sum_d;
        logic [NA*(WI+1)-1:0] sum_q;
        logic                 sgn_q;
        logic                 vld_q;
        logic [TAG_W-1:0]     tag_q;

        if (l == 1) begin : g_first
            assign src_ops = in_ops;
            assign src_sgn = in_signed;
            assign src_vld = in_valid;
            assign src_tag = in_tag;
        end else begin : g_rest
            // Each level adds using the signed flag registered with its own data.
            assign src_ops = g_lvl[l-1].sum_q;
            assign src_sgn = g_lvl[l-1].sgn_q;
            assign src_vld = g_lvl[l-1].vld_q;
            assign src_tag = g_lvl[l-1].tag_q;
        end

        rca_level #(
            .NA (NA),
            .WI (WI)
        ) u_rca (
            .ops_i (src_ops),
            .sgn_i (src_sgn),
            .sum_o (sum_d)
        );

        // Data loads even for bubbles; only the valid bit marks content.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                sgn_q <= 1'b0;
                vld_q <= 1'b0;
                tag_q <= '0;
            end else if (adv) begin
                sum_q <= sum_d;
                sgn_q <= src_sgn;
                vld_q <= src_vld;
                tag_q <= src_tag;
            end
        end
    end

    assign out_valid = g_lvl[N_LVL].vld_q;
    assign out_tag   = g_lvl[N_LVL].tag_q;
    assign out_sum   = OUT_W'(g_lvl[N_LVL].sum_q);

endmodule

// File: tb/tb_bta_pipe_adder.sv
// tb/tb_bta_pipe_adder.sv - self-checking scoreboard bench for bta_pipe_adder
module tb_bta_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Default configuration: N_OPS=8, W=16, TAG_W=4 -> 19-bit sum
    logic         d_in_valid;
    logic         d_in_ready;
    logic [127:0] d_in_ops;
    logic         d_in_signed;
    logic [3:0]   d_in_tag;
    logic         d_out_valid;
    logic         d_out_ready;
    logic [18:0]  d_out_sum;
    logic [3:0]   d_out_tag;

    bta_pipe_adder #(.N_OPS(8), .W(16), .TAG_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_ops    (d_in_ops),
        .in_signed (d_in_signed),
        .in_tag    (d_in_tag),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_sum   (d_out_sum),
        .out_tag   (d_out_tag)
    );

    // Regression configurations: (N_OPS, W) = (2,33), (4,4), (16,16)
    localparam int RN [3] = '{2, 4, 16};
    localparam int RW [3] = '{33, 4, 16};
    localparam int RO [3] = '{34, 6, 20};

    logic [2:0]   r_in_valid;
    logic [2:0]   r_in_ready;
    logic [2:0]   r_in_signed;
    logic [2:0]   r_out_valid;
    logic [2:0]   r_out_ready;
    logic [255:0] r_ops;
    logic [3:0]   r_in_tag  [3];
    logic [3:0]   r_out_tag [3];
    logic [33:0]  r0_sum;
    logic [5:0]   r1_sum;
    logic [19:0]  r2_sum;
    logic [63:0]  r_sum [3];
    logic [67:0]  rq [3][$];

    assign r_sum[0] = 64'(r0_sum);
    assign r_sum[1] = 64'(r1_sum);
    assign r_sum[2] = 64'(r2_sum);

    bta_pipe_adder #(.N_OPS(2), .W(33), .TAG_W(4)) u_r0 (
        .clk (clk), .rst (rst),
        .in_valid (r_in_valid[0]), .in_ready (r_in_ready[0]),
        .in_ops (r_ops[65:0]), .in_signed (r_in_signed[0]), .in_tag (r_in_tag[0]),
        .out_valid (r_out_valid[0]), .out_ready (r_out_ready[0]),
        .out_sum (r0_sum), .out_tag (r_out_tag[0])
    );

    bta_pipe_adder #(.N_OPS(4), .W(4), .TAG_W(4)) u_r1 (
        .clk (clk), .rst (rst),
        .in_valid (r_in_valid[1]), .in_ready (r_in_ready[1]),
        .in_ops (r_ops[15:0]), .in_signed (r_in_signed[1]), .in_tag (r_in_tag[1]),
        .out_valid (r_out_valid[1]), .out_ready (r_out_ready[1]),
        .out_sum (r1_sum), .out_tag (r_out_tag[1])
    );

    bta_pipe_adder #(.N_OPS(16), .W(16), .TAG_W(4)) u_r2 (
        .clk (clk), .rst (rst),
        .in_valid (r_in_valid[2]), .in_ready (r_in_ready[2]),
        .in_ops (r_ops[255:0]), .in_signed (r_in_signed[2]), .in_tag (r_in_tag[2]),
        .out_valid (r_out_valid[2]), .out_ready (r_out_ready[2]),
        .out_sum (r2_sum), .out_tag (r_out_tag[2])
    );

    // Reference model: extend each operand to 64 bits and add.
    function automatic logic [63:0] ref_sum(input logic [255:0] ops, input int n,
                                            input int w, input logic sgn);
        logic [63:0] acc;
        logic [63:0] v;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            v = '0;
            for (int b = 0; b < w; b++) v[b] = ops[i*w+b];
            if (sgn && v[w-1]) begin
                for (int b = w; b < 64; b++) v[b] = 1'b1;
            end
            acc = acc + v;
        end
        return acc;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (d_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", d_out_valid);
        else n_pass++;
        n_checks++;
        if (d_out_sum !== 19'h0) $display("FAIL reset_out_sum: got %h expected 0", d_out_sum);
        else n_pass++;
        n_checks++;
        if (d_out_tag !== 4'h0) $display("FAIL reset_out_tag: got %h expected 0", d_out_tag);
        else n_pass++;
        n_checks++;
        if (d_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", d_in_ready);
        else n_pass++;
        rst = 1'b0;
    endtask

    // One isolated vector: checks the exact 3-cycle latency, then sum and tag.
    task automatic run_single(input logic [127:0] ops, input logic sgn, input logic [3:0] tag,
                              input logic [18:0] exp_sum, input string nm);
        @(negedge clk);
        d_in_valid  = 1'b1;
        d_in_ops    = ops;
        d_in_signed = sgn;
        d_in_tag    = tag;
        d_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (d_out_valid !== (i == 2))
                $display("FAIL %s_latency: cycle %0d out_valid got %b expected %b", nm, i, d_out_valid, (i == 2));
            else n_pass++;
        end
        n_checks++;
        if (d_out_sum !== exp_sum) $display("FAIL %s_sum: got %h expected %h", nm, d_out_sum, exp_sum);
        else n_pass++;
        n_checks++;
        if (d_out_tag !== tag) $display("FAIL %s_tag: got %h expected %h", nm, d_out_tag, tag);
        else n_pass++;
    endtask

    task automatic test_corners();
        run_single({8{16'hFFFF}}, 1'b0, 4'h3, 19'h7FFF8, "unsigned_all_ones");
        run_single({112'h0, 16'hFFFF}, 1'b1, 4'h5, 19'h7FFFF, "signed_minus_one");
        run_single({112'h0, 16'hFFFF}, 1'b0, 4'h6, 19'h0FFFF, "unsigned_ffff");
        run_single({8{16'h8000}}, 1'b1, 4'h9, 19'h40000, "signed_all_min");
        run_single({8{16'h7FFF}}, 1'b1, 4'hC, 19'h3FFF8, "signed_all_max");
    endtask

    task automatic test_back_to_back();
        logic [22:0] exp_q [$];
        logic [22:0] e;
        logic [63:0] s;
        int          sent;
        int          got;
        logic        stalled;
        logic [18:0] held_sum;
        logic [3:0]  held_tag;
        sent     = 0;
        got      = 0;
        stalled  = 1'b0;
        held_sum = '0;
        held_tag = '0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            @(negedge clk);
            d_out_ready = (c % 3 == 0);
            d_in_valid  = (sent < 10);
            d_in_signed = 1'($urandom_range(0, 1));
            d_in_tag    = 4'(sent);
            for (int i = 0; i < 4; i++) d_in_ops[i*32 +: 32] = $urandom;
            #1;
            if (stalled) begin
                n_checks++;
                if (d_out_valid !== 1'b1 || d_out_sum !== held_sum || d_out_tag !== held_tag)
                    $display("FAIL b2b_stall_hold: got v=%b sum=%h tag=%h expected v=1 sum=%h tag=%h",
                             d_out_valid, d_out_sum, d_out_tag, held_sum, held_tag);
                else n_pass++;
            end
            if (d_out_valid && !d_out_ready) begin
                n_checks++;
                if (d_in_ready !== 1'b0) $display("FAIL b2b_in_ready_stall: got %b expected 0", d_in_ready);
                else n_pass++;
            end
            if (d_out_valid && d_out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra_output: got tag %h sum %h expected none", d_out_tag, d_out_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({d_out_tag, d_out_sum} !== e)
                        $display("FAIL b2b_result: got tag %h sum %h expected tag %h sum %h",
                                 d_out_tag, d_out_sum, e[22:19], e[18:0]);
                    else n_pass++;
                end
                got++;
            end
            if (d_in_valid && d_in_ready) begin
                s = ref_sum({128'h0, d_in_ops}, 8, 16, d_in_signed);
                exp_q.push_back({d_in_tag, s[18:0]});
                sent++;
            end
            stalled  = d_out_valid && !d_out_ready;
            held_sum = d_out_sum;
            held_tag = d_out_tag;
        end
        @(negedge clk);
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        n_checks++;
        if (got != 10 || exp_q.size() != 0)
            $display("FAIL b2b_count: got %0d results with %0d pending, expected 10 and 0", got, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int seen;
        seen = 0;
        @(negedge clk);
        d_out_ready = 1'b0;
        d_in_valid  = 1'b1;
        d_in_signed = 1'b0;
        d_in_ops    = {8{16'h1111}};
        d_in_tag    = 4'hA;
        @(negedge clk);
        d_in_ops    = {8{16'h2222}};
        d_in_tag    = 4'hB;
        @(negedge clk);
        d_in_valid  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_out_valid !== 1'b1) $display("FAIL rst_mid_pre_valid: got %b expected 1", d_out_valid);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (d_out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b expected 0", d_out_valid);
        else n_pass++;
        n_checks++;
        if (d_out_sum !== 19'h0) $display("FAIL rst_mid_out_sum: got %h expected 0", d_out_sum);
        else n_pass++;
        n_checks++;
        if (d_out_tag !== 4'h0) $display("FAIL rst_mid_out_tag: got %h expected 0", d_out_tag);
        else n_pass++;
        n_checks++;
        if (d_in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b expected 1", d_in_ready);
        else n_pass++;
        @(negedge clk);
        rst         = 1'b0;
        d_out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (d_out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL rst_mid_discard: got %0d stale outputs expected 0", seen);
        else n_pass++;
        run_single({8{16'h0101}}, 1'b0, 4'h7, 19'h00808, "after_reset");
    endtask

    task automatic test_random();
        logic [67:0] e;
        logic [63:0] s;
        logic [63:0] mask;
        for (int c = 0; c < 840; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) r_ops[i*32 +: 32] = $urandom;
            if ($urandom_range(0, 7) == 0) r_ops = '1;
            for (int k = 0; k < 3; k++) begin
                r_in_valid[k]  = ($urandom_range(0, 3) != 0) && (c < 800);
                r_out_ready[k] = ($urandom_range(0, 3) != 0) || (c >= 800);
                r_in_signed[k] = 1'($urandom_range(0, 1));
                r_in_tag[k]    = 4'($urandom);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                if (r_out_valid[k] && r_out_ready[k]) begin
                    n_checks++;
                    if (rq[k].size() == 0) begin
                        $display("FAIL rand%0d_extra_output: got tag %h sum %h expected none",
                                 k, r_out_tag[k], r_sum[k]);
                    end else begin
                        e = rq[k].pop_front();
                        if ({r_out_tag[k], r_sum[k]} !== e)
                            $display("FAIL rand%0d_result: got tag %h sum %h expected tag %h sum %h",
                                     k, r_out_tag[k], r_sum[k], e[67:64], e[63:0]);
                        else n_pass++;
                    end
                end
                if (r_in_valid[k] && r_in_ready[k]) begin
                    s    = ref_sum(r_ops, RN[k], RW[k], r_in_signed[k]);
                    mask = (64'd1 << RO[k]) - 64'd1;
                    rq[k].push_back({r_in_tag[k], s & mask});
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rq[k].size() != 0) $display("FAIL rand%0d_drain: got %0d pending expected 0", k, rq[k].size());
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        d_in_valid  = 1'b0;
        d_in_ops    = '0;
        d_in_signed = 1'b0;
        d_in_tag    = '0;
        d_out_ready = 1'b0;
        r_in_valid  = '0;
        r_in_signed = '0;
        r_out_ready = '0;
        r_ops       = '0;
        for (int k = 0; k < 3; k++) r_in_tag[k] = '0;

        test_reset();
        test_corners();
        test_back_to_back();
        test_reset_midstream();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
